uart_note_rx: RTL and testbench
===============================

# uart_note_rx

Serial receiver for the note/screen link. It deserializes 8N1 UART frames (start bit 0, 8 data bits LSB first, stop bit 1) and outputs each received byte. It also decodes the byte as an ASCII note code into a 13-key index and one-hot. It sits at the control/display end of the link, opposite the keyboard-side frame builder, and drives note selection from the serial stream.

## Interface
- CLK_HZ, 50_000_000: system clock frequency.
- BAUD, 9600: line bit rate.
- TICK_DIV, CLK_HZ/(BAUD*16): clocks per oversample tick. Integer, truncated, must be ≥2.
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- rx  in  1  asynchronous serial line; idles high.
- data  out  8  last correctly framed byte; held until the next good frame.
- data_valid  out  1  one-cycle pulse when `data` updates.
- frame_err  out  1  one-cycle pulse when the stop bit samples 0.
- note_valid  out  1  one-cycle pulse, coincident with `data_valid`, when the byte is a note code.
- note_index  out  4  index 0–12 of the last decoded note; held.
- note_onehot  out  13  one-hot of `note_index`; all zero until the first note.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. All decisions use the synchronized value `rxs`.
- The tick divider counts 0..TICK_DIV-1 and emits a one-cycle `tick` at TICK_DIV-1. A 4-bit `os_cnt` counts ticks within a bit.
- **IDLE:** when `rxs`=0, clear the divider and `os_cnt`, then go to START.
- **START:** at `os_cnt`=7 (mid start bit), resample `rxs`.
  - If 1, this is a glitch: return to IDLE with no output.
  - If 0, clear `os_cnt` and go to DATA with `bit_cnt`=0.
- **DATA:** at `os_cnt`=15, shift `rxs` into `shreg[7]` and shift right, so LSB arrives first.
  - After the 8th bit, go to STOP.
- **STOP:** at `os_cnt`=15, sample the stop bit.
  - If 1: load `data`, pulse `data_valid`, run note decode, return to IDLE.
  - If 0: pulse `frame_err`, leave `data` unchanged, go to BREAK.
- **BREAK:** stay until `rxs`=1, then go to IDLE. A continuous low line yields exactly one `frame_err`.
- Note decode, case-sensitive. Index ← byte:
  - 0 ← 'C' (0x43)
  - 1 ← 'c' (0x63)
  - 2 ← 'D' (0x44)
  - 3 ← 'd' (0x64)
  - 4 ← 'E' (0x45)
  - 5 ← 'F' (0x46)
  - 6 ← 'f' (0x66)
  - 7 ← 'G' (0x47)
  - 8 ← 'g' (0x67)
  - 9 ← 'A' (0x41)
  - 10 ← 'a' (0x61)
  - 11 ← 'B' (0x42)
  - Index 12 has no code; it is reachable only as an index value.
- Any other byte gives `data_valid` without `note_valid`; `note_index`/`note_onehot` stay unchanged.

## Timing
- Reset (`reset_n`=0 at a clock edge) takes effect at that edge, including mid-frame, and aborts the frame with no pulse. Reset values:
  - state IDLE
  - `data`=0x00, `note_index`=0, `note_onehot`=0
  - all pulses 0, `busy`=0
  - synchronizer flops = 1
- Let T0 be the edge where IDLE sees `rxs`=0, i.e. 2–3 clocks after the `rx` fall.
- Sample points after T0:
  - start sample at 8·TICK_DIV clocks
  - data bit k (k=0..7) at (8+16(k+1))·TICK_DIV
  - stop sample at 152·TICK_DIV
- `data_valid`, `note_valid` and `frame_err` are registered. They assert on the clock after the stop sample, for exactly 1 cycle.
- `data`, `note_index` and `note_onehot` change on the same edge their pulse asserts.
- Back-to-back frames:
  - IDLE is re-entered on the stop-sample edge.
  - A start edge arriving half a bit later is accepted.
  - There is no gap requirement beyond the stop bit.
- `busy` rises on the edge after T0 and falls on the edge that returns to IDLE.

## Test plan
Bench uses CLK_HZ=1_600_000, BAUD=10_000, so TICK_DIV=10 and one bit = 160 clocks.
- **Note 'A':** send 0x41 → `data`=0x41, `data_valid` and `note_valid` pulse 1 cycle, `note_index`=9, `note_onehot`=13'h0200, `frame_err` never asserts.
- **Back-to-back frames:** send 'C' then 'a' with no idle gap → two `data_valid` pulses 1600±20 clocks apart, `note_index` goes 0 then 10, onehot 13'h0001 then 13'h0400.
- **Non-note byte:** send 0x5A → `data_valid` pulses, `data`=0x5A, no `note_valid`, `note_index` unchanged from the previous value.
- **Framing error:** send 0x43 with stop bit 0, hold `rx` low 3000 clocks, then release → exactly one `frame_err`, no `data_valid`, `data` unchanged. A following 0x44 frame decodes to index 2.
- **Glitch:** drive `rx` low for 30 clocks → no pulses, `busy` returns low ≤90 clocks after T0, and the next frame decodes correctly.
- **Reset mid-frame:** assert `reset_n`=0 for 1 cycle during bit 4 of a frame → all outputs at reset values on the next edge, no pulse. The remainder of the frame produces no output (leftover bits are 1s or rejected as a glitch). A fresh 0x42 frame then gives index 11.

Source files
------------

// File: rtl/uart_note_rx.sv
// 8N1 UART receiver for the note/screen link: 16x oversampled deserializer
// with a registered ASCII note-code decoder (13-key index and one-hot).
module uart_note_rx #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int BAUD     = 9600,
   parameter int TICK_DIV = CLK_HZ / (BAUD * 16)
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx,
   output logic [7:0]  data,
   output logic        data_valid,
   output logic        frame_err,
   output logic        note_valid,
   output logic [3:0]  note_index,
   output logic [12:0] note_onehot,
   output logic        busy
);

   localparam int DIV_W = $clog2(TICK_DIV);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   logic             rx_meta_r, rxs_r;
   state_t           state_r, state_s;
   logic [DIV_W-1:0] div_cnt_r, div_cnt_s;
   logic [3:0]       os_cnt_r, os_cnt_s;
   logic [2:0]       bit_cnt_r, bit_cnt_s;
   logic [7:0]       shreg_r, shreg_s;
   logic [7:0]       data_r, data_s;
   logic             data_valid_r, data_valid_s;
   logic             frame_err_r, frame_err_s;
   logic             note_valid_r, note_valid_s;
   logic [3:0]       note_index_r, note_index_s;
   logic [12:0]      note_onehot_r, note_onehot_s;
   logic             busy_r, busy_s;
   logic             tick_s;
   logic [4:0]       decode_s;

   // Returns {hit, index}; case-sensitive, index 12 has no code.
   function automatic logic [4:0] note_decode(input logic [7:0] b);
      case (b)
         8'h43:   note_decode = {1'b1, 4'd0};
         8'h63:   note_decode = {1'b1, 4'd1};
         8'h44:   note_decode = {1'b1, 4'd2};
         8'h64:   note_decode = {1'b1, 4'd3};
         8'h45:   note_decode = {1'b1, 4'd4};
         8'h46:   note_decode = {1'b1, 4'd5};
         8'h66:   note_decode = {1'b1, 4'd6};
         8'h47:   note_decode = {1'b1, 4'd7};
         8'h67:   note_decode = {1'b1, 4'd8};
         8'h41:   note_decode = {1'b1, 4'd9};
         8'h61:   note_decode = {1'b1, 4'd10};
         8'h42:   note_decode = {1'b1, 4'd11};
         default: note_decode = {1'b0, 4'd0};
      endcase
   endfunction

   // Next-state and next-output logic for the receive FSM.
   always_comb begin
      tick_s        = (div_cnt_r == DIV_W'(TICK_DIV - 1));
      decode_s      = note_decode(shreg_r);
      state_s       = state_r;
      div_cnt_s     = tick_s ? '0 : div_cnt_r + DIV_W'(1);
      os_cnt_s      = tick_s ? os_cnt_r + 4'd1 : os_cnt_r;
      bit_cnt_s     = bit_cnt_r;
      shreg_s       = shreg_r;
      data_s        = data_r;
      data_valid_s  = 1'b0;
      frame_err_s   = 1'b0;
      note_valid_s  = 1'b0;
      note_index_s  = note_index_r;
      note_onehot_s = note_onehot_r;

      case (state_r)
         S_IDLE: begin
            if (!rxs_r) begin
               div_cnt_s = '0;
               os_cnt_s  = 4'd0;
               state_s   = S_START;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_START: begin
            // Mid start bit: a high line here means the fall was a glitch.
            if (tick_s && (os_cnt_r == 4'd7)) begin
               if (rxs_r) begin
                  state_s = S_IDLE;
               end else begin
                  os_cnt_s  = 4'd0;
                  bit_cnt_s = 3'd0;
                  state_s   = S_DATA;
               end
            end else begin
               state_s = S_START;
            end
         end
         S_DATA: begin
            if (tick_s && (os_cnt_r == 4'd15)) begin
               shreg_s = {rxs_r, shreg_r[7:1]};
               if (bit_cnt_r == 3'd7) begin
                  state_s = S_STOP;
               end else begin
                  bit_cnt_s = bit_cnt_r + 3'd1;
               end
            end else begin
               state_s = S_DATA;
            end
         end
         S_STOP: begin
            if (tick_s && (os_cnt_r == 4'd15)) begin
               if (rxs_r) begin
                  data_s       = shreg_r;
                  data_valid_s = 1'b1;
                  state_s      = S_IDLE;
                  if (decode_s[4]) begin
                     note_valid_s  = 1'b1;
                     note_index_s  = decode_s[3:0];
                     note_onehot_s = 13'd1 << decode_s[3:0];
                  end else begin
                     note_valid_s = 1'b0;
                  end
               end else begin
                  frame_err_s = 1'b1;
                  state_s     = S_BREAK;
               end
            end else begin
               state_s = S_STOP;
            end
         end
         S_BREAK: begin
            // One frame_err per low stretch: wait for the line to recover.
            if (rxs_r) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_BREAK;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase

      busy_s = (state_s != S_IDLE);
   end

   // Synchronizer, FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_meta_r     <= 1'b1;
         rxs_r         <= 1'b1;
         state_r       <= S_IDLE;
         div_cnt_r     <= '0;
         os_cnt_r      <= 4'd0;
         bit_cnt_r     <= 3'd0;
         shreg_r       <= 8'h00;
         data_r        <= 8'h00;
         data_valid_r  <= 1'b0;
         frame_err_r   <= 1'b0;
         note_valid_r  <= 1'b0;
         note_index_r  <= 4'd0;
         note_onehot_r <= 13'd0;
         busy_r        <= 1'b0;
      end else begin
         rx_meta_r     <= rx;
         rxs_r         <= rx_meta_r;
         state_r       <= state_s;
         div_cnt_r     <= div_cnt_s;
         os_cnt_r      <= os_cnt_s;
         bit_cnt_r     <= bit_cnt_s;
         shreg_r       <= shreg_s;
         data_r        <= data_s;
         data_valid_r  <= data_valid_s;
         frame_err_r   <= frame_err_s;
         note_valid_r  <= note_valid_s;
         note_index_r  <= note_index_s;
         note_onehot_r <= note_onehot_s;
         busy_r        <= busy_s;
      end
   end

   assign data        = data_r;
   assign data_valid  = data_valid_r;
   assign frame_err   = frame_err_r;
   assign note_valid  = note_valid_r;
   assign note_index  = note_index_r;
   assign note_onehot = note_onehot_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_uart_note_rx.sv
// Self-checking bench for uart_note_rx: directed and random frames against a
// frame-level scoreboard of expected pulses, times and held outputs.
module tb_uart_note_rx;

   localparam int CLK_HZ = 1_600_000;
   localparam int BAUD   = 10_000;
   localparam int BITC   = 160;
   // rx fall -> 2 sync clocks -> T0 -> stop sample at 152 ticks of 10 clocks
   localparam int LAT    = 3 + 152 * 10;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx = 1'b1;
   logic [7:0]  data;
   logic        data_valid, frame_err, note_valid, busy;
   logic [3:0]  note_index;
   logic [12:0] note_onehot;

   uart_note_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .clk(clk), .reset_n(reset_n), .rx(rx), .data(data),
      .data_valid(data_valid), .frame_err(frame_err), .note_valid(note_valid),
      .note_index(note_index), .note_onehot(note_onehot), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      bit         err;
      logic [7:0] b;
   } exp_t;

   exp_t        exp_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_fe = 0;
   int          dv_last = 0;
   int          dv_prev = 0;
   bit          mon_on = 1'b0;
   logic [7:0]  mdl_data = 8'h00;
   logic [3:0]  mdl_idx = 4'd0;
   logic [12:0] mdl_oh = 13'd0;
   string       keys = "CcDdEFfGgAaB";

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Note index is the position of the byte in the key string, if present.
   function automatic bit note_of(input logic [7:0] b, output logic [3:0] idx);
      note_of = 1'b0;
      idx = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (keys[i] == b) begin
            note_of = 1'b1;
            idx = 4'(i);
         end
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t       e;
      logic [3:0] idx;
      bit         hit;
      if (mon_on) begin
         if (frame_err) n_fe++;
         if (data_valid) begin
            dv_prev = dv_last;
            dv_last = cyc;
         end
         if (note_valid && !data_valid) chk("note_valid_alone", 32'(note_valid), 32'd0);
         if (data_valid || frame_err) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {30'd0, data_valid, frame_err}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_kind_fe", 32'(frame_err), 32'(e.err));
               chk("pulse_kind_dv", 32'(data_valid), 32'(!e.err));
               n_checks++;
               if (cyc < e.due - 2 || cyc > e.due + 2) begin
                  n_fail++;
                  $display("FAIL pulse_time: got cycle %0d, expected %0d", cyc, e.due);
               end
               hit = 1'b0;
               if (!e.err) begin
                  mdl_data = e.b;
                  hit = note_of(e.b, idx);
                  if (hit) begin
                     mdl_idx = idx;
                     mdl_oh  = 13'd1 << idx;
                  end
               end
               chk("note_valid", 32'(note_valid), 32'(hit));
            end
         end else if (exp_q.size() > 0 && cyc > exp_q[0].due + 2) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_pulse: got none by cycle %0d, expected at %0d", cyc, exp_q[0].due);
            void'(exp_q.pop_front());
         end
         chk("data", 32'(data), 32'(mdl_data));
         chk("note_index", 32'(note_index), 32'(mdl_idx));
         chk("note_onehot", 32'(note_onehot), 32'(mdl_oh));
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1 rx = 1'b1;
      end
   endtask

   // One 10-bit frame; optional one-cycle reset pulse at offset reset_at.
   task automatic send_frame(input logic [7:0] b, input logic stopb,
                             input bit expect_out, input int reset_at);
      for (int off = 0; off < 10 * BITC; off++) begin
         @(posedge clk);
         #1;
         if (off == 0 && expect_out) exp_q.push_back('{cyc + LAT, !stopb, b});
         if (off < BITC) rx = 1'b0;
         else if (off < 9 * BITC) rx = b[(off - BITC) / BITC];
         else rx = stopb;
         if (off == reset_at) reset_n = 1'b0;
         if (reset_at >= 0 && off == reset_at + 1) begin
            reset_n  = 1'b1;
            mdl_data = 8'h00;
            mdl_idx  = 4'd0;
            mdl_oh   = 13'd0;
            @(negedge clk);
            chk("rst_mid_data", 32'(data), 32'h00);
            chk("rst_mid_index", 32'(note_index), 32'd0);
            chk("rst_mid_onehot", 32'(note_onehot), 32'd0);
            chk("rst_mid_busy", 32'(busy), 32'd0);
            chk("rst_mid_dv", 32'(data_valid), 32'd0);
         end
      end
   endtask

   initial begin
      int         g;
      logic [7:0] b;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("reset_data", 32'(data), 32'h00);
      chk("reset_onehot", 32'(note_onehot), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_pulses", {29'd0, data_valid, frame_err, note_valid}, 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      mon_on = 1'b1;
      idle(50);

      send_frame(8'h41, 1'b1, 1'b1, -1);
      chk("A_data", 32'(data), 32'h41);
      chk("A_index", 32'(note_index), 32'd9);
      chk("A_onehot", 32'(note_onehot), 32'h0200);
      chk("A_no_fe", 32'(n_fe), 32'd0);

      send_frame(8'h43, 1'b1, 1'b1, -1);
      chk("C_index", 32'(note_index), 32'd0);
      chk("C_onehot", 32'(note_onehot), 32'h0001);
      send_frame(8'h61, 1'b1, 1'b1, -1);
      chk("a_index", 32'(note_index), 32'd10);
      chk("a_onehot", 32'(note_onehot), 32'h0400);
      chk("b2b_gap", 32'(dv_last - dv_prev), 32'd1600);

      send_frame(8'h5A, 1'b1, 1'b1, -1);
      chk("nonnote_data", 32'(data), 32'h5A);
      chk("nonnote_index", 32'(note_index), 32'd10);

      send_frame(8'h43, 1'b0, 1'b1, -1);
      repeat (3000) @(posedge clk);
      idle(200);
      chk("break_fe_count", 32'(n_fe), 32'd1);
      chk("break_data", 32'(data), 32'h5A);
      send_frame(8'h44, 1'b1, 1'b1, -1);
      chk("D_index", 32'(note_index), 32'd2);

      // Glitch: 30 clocks low, rejected at the mid-start-bit sample.
      @(posedge clk);
      #1 rx = 1'b0;
      g = cyc;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (i == 30) rx = 1'b1;
         if (i == 20) chk("glitch_busy_high", 32'(busy), 32'd1);
         if (i == 95) chk("glitch_busy_low", 32'(busy), 32'd0);
      end
      chk("glitch_elapsed", 32'(cyc - g), 32'd100);
      send_frame(8'h45, 1'b1, 1'b1, -1);
      chk("E_index", 32'(note_index), 32'd4);

      // Reset during bit 4 of 0xF3; bits 4..7 and stop are all 1.
      send_frame(8'hF3, 1'b1, 1'b0, 5 * BITC + 60);
      idle(100);
      send_frame(8'h42, 1'b1, 1'b1, -1);
      chk("B_index", 32'(note_index), 32'd11);
      chk("B_onehot", 32'(note_onehot), 32'h0800);

      for (int k = 0; k < 20; k++) begin
         if ($urandom_range(0, 1) == 1) b = keys[$urandom_range(0, 11)];
         else b = 8'($urandom);
         send_frame(b, 1'b1, 1'b1, -1);
         idle($urandom_range(0, 100));
      end

      idle(100);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      chk("final_fe_count", 32'(n_fe), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
